matmul_tile_sched: RTL and testbench

// - Computes a DIMxDIM signed matrix product C = A*B by sequencing one external 2x2 Strassen engine over 2x2 tiles.
// - Issues T^3 tile jobs (T = DIM/2) through a start/valid handshake and accumulates tile products into a C register bank.
// - Sits between the host-side matrix registers and the shared matmul_2x2 engine.

---
 rtl/matmul_pkg.sv | 18 +
 rtl/matmul_tile_sched_if.sv | 18 +
 rtl/matmul_tile_sel.sv | 37 +++
 rtl/matmul_tile_sched.sv | 180 ++++++++++++++++++
 tb/tb_matmul_tile_sched.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/matmul_pkg.sv
// Shared types and width helpers for the tile scheduler and its engine link.
package matmul_pkg;

  localparam int BIT_PREC_DEF = 8;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} sched_state_t;

  // Width of one 2x2 engine result element: two full products summed.
  function automatic int eng_w(input int bit_prec);
    return 2 * bit_prec + 1;
  endfunction

  // Accumulator width: engine width plus headroom for T tile products.
  function automatic int acc_w(input int bit_prec, input int dim);
    return 2 * bit_prec + 1 + $clog2(dim / 2);
  endfunction

endpackage

// File: rtl/matmul_tile_sched_if.sv
// Link between the tile scheduler (master) and a shared 2x2 matmul engine (slave).
interface matmul_tile_sched_if
  import matmul_pkg::*;
#(
  parameter  int BIT_PREC = BIT_PREC_DEF,
  localparam int ENG_W    = eng_w(BIT_PREC)
) ();

  logic                                eng_start;
  logic [1:0][1:0][BIT_PREC-1:0]       eng_A;
  logic [1:0][1:0][BIT_PREC-1:0]       eng_B;
  logic [1:0][1:0][ENG_W-1:0]          eng_C;
  logic                                eng_valid;

  modport master (output eng_start, eng_A, eng_B, input eng_C, eng_valid);
  modport slave  (input eng_start, eng_A, eng_B, output eng_C, eng_valid);

endinterface

// File: rtl/matmul_tile_sel.sv
// Combinational 2x2 tile extraction: A tile(i,k) and B tile(k,j).
module matmul_tile_sel
  import matmul_pkg::*;
#(
  parameter  int BIT_PREC = BIT_PREC_DEF,
  parameter  int DIM      = 4,
  localparam int T        = DIM / 2,
  localparam int IW       = (T > 1) ? $clog2(T) : 1,
  localparam int IDXW     = $clog2(DIM)
) (
  input  logic [DIM-1:0][DIM-1:0][BIT_PREC-1:0] a,
  input  logic [DIM-1:0][DIM-1:0][BIT_PREC-1:0] b,
  input  logic [IW-1:0]                         ti,
  input  logic [IW-1:0]                         tj,
  input  logic [IW-1:0]                         tk,
  output logic [1:0][1:0][BIT_PREC-1:0]         tile_a,
  output logic [1:0][1:0][BIT_PREC-1:0]         tile_b
);

  // Row/column of element o inside tile t.
  function automatic logic [IDXW-1:0] tix(input logic [IW-1:0] t, input int o);
    return IDXW'(2 * int'(t) + o);
  endfunction

  // Pick the four elements of each tile.
  always_comb begin
    tile_a = '0;
    tile_b = '0;
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < 2; c++) begin
        tile_a[r][c] = a[tix(ti, r)][tix(tk, c)];
        tile_b[r][c] = b[tix(tk, r)][tix(tj, c)];
      end
    end
  end

endmodule

// File: rtl/matmul_tile_sched.sv
// DIMxDIM signed matmul by sequencing one external 2x2 engine over T^3 tile jobs
// (i outer, j middle, k inner). Optional busy-cycle counter: MATMUL_SCHED_PERF_EN.
module matmul_tile_sched
  import matmul_pkg::*;
#(
  parameter  int BIT_PREC = BIT_PREC_DEF,
  parameter  int DIM      = 4,
  localparam int T        = DIM / 2,
  localparam int ENG_W    = eng_w(BIT_PREC),
  localparam int ACC_W    = acc_w(BIT_PREC, DIM),
  localparam int IW       = (T > 1) ? $clog2(T) : 1,
  localparam int IDXW     = $clog2(DIM)
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  start,
  input  logic [DIM-1:0][DIM-1:0][BIT_PREC-1:0] A,
  input  logic [DIM-1:0][DIM-1:0][BIT_PREC-1:0] B,
  output logic                                  busy,
  output logic                                  done,
  output logic [DIM-1:0][DIM-1:0][ACC_W-1:0]    C,
`ifdef MATMUL_SCHED_PERF_EN
  output logic [15:0]                           perf_cycles,
`endif
  matmul_tile_sched_if.master                   eng
);

  sched_state_t                           state;
  logic [IW-1:0]                          ti, tj, tk;
  logic [IW-1:0]                          nxt_i, nxt_j, nxt_k;
  logic                                   last;
  logic [DIM-1:0][DIM-1:0][BIT_PREC-1:0]  a_q, b_q;
  logic [DIM-1:0][DIM-1:0][BIT_PREC-1:0]  sel_a, sel_b;
  logic [IW-1:0]                          sel_i, sel_j, sel_k;
  logic [1:0][1:0][BIT_PREC-1:0]          tile_a, tile_b;
  logic [1:0][1:0][BIT_PREC-1:0]          eng_a_q, eng_b_q;
  logic                                   eng_start_q;
  logic [DIM-1:0][DIM-1:0][ACC_W-1:0]     c_q;

  function automatic logic [IDXW-1:0] tix(input logic [IW-1:0] t, input int o);
    return IDXW'(2 * int'(t) + o);
  endfunction

  // Next job indices; wrap to (0,0,0) after the last job.
  always_comb begin
    nxt_i = ti;
    nxt_j = tj;
    nxt_k = tk;
    last  = (ti == IW'(T - 1)) && (tj == IW'(T - 1)) && (tk == IW'(T - 1));
    if (tk == IW'(T - 1)) begin
      nxt_k = '0;
      if (tj == IW'(T - 1)) begin
        nxt_j = '0;
        nxt_i = ti + 1'b1;
      end else begin
        nxt_j = tj + 1'b1;
      end
    end else begin
      nxt_k = tk + 1'b1;
    end
    if (last) begin
      nxt_i = '0;
      nxt_j = '0;
      nxt_k = '0;
    end
  end

  // In IDLE the first tile comes straight from the host matrices, since
  // the latched copies only become valid on the accept edge.
  always_comb begin
    sel_a = (state == IDLE) ? A : a_q;
    sel_b = (state == IDLE) ? B : b_q;
    sel_i = (state == IDLE) ? '0 : nxt_i;
    sel_j = (state == IDLE) ? '0 : nxt_j;
    sel_k = (state == IDLE) ? '0 : nxt_k;
  end

  matmul_tile_sel #(.BIT_PREC(BIT_PREC), .DIM(DIM)) u_sel (
    .a      (sel_a),
    .b      (sel_b),
    .ti     (sel_i),
    .tj     (sel_j),
    .tk     (sel_k),
    .tile_a (tile_a),
    .tile_b (tile_b)
  );

  // Scheduler FSM: issue a job, wait for the engine, accumulate, repeat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      eng_start_q <= 1'b0;
      eng_a_q     <= '0;
      eng_b_q     <= '0;
      c_q         <= '0;
      ti          <= '0;
      tj          <= '0;
      tk          <= '0;
      a_q         <= '0;
      b_q         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_q         <= A;
            b_q         <= B;
            ti          <= '0;
            tj          <= '0;
            tk          <= '0;
            eng_a_q     <= tile_a;
            eng_b_q     <= tile_b;
            eng_start_q <= 1'b1;
            busy        <= 1'b1;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          eng_start_q <= 1'b0;
          state       <= WAIT;
        end
        WAIT: begin
          if (eng.eng_valid) begin
            // k==0 overwrites so the previous result stays visible until now.
            for (int r = 0; r < 2; r++) begin
              for (int c = 0; c < 2; c++) begin
                if (tk == '0)
                  c_q[tix(ti, r)][tix(tj, c)] <= ACC_W'($signed(eng.eng_C[r][c]));
                else
                  c_q[tix(ti, r)][tix(tj, c)] <= ACC_W'($signed(c_q[tix(ti, r)][tix(tj, c)]))
                                                 + ACC_W'($signed(eng.eng_C[r][c]));
              end
            end
            ti      <= nxt_i;
            tj      <= nxt_j;
            tk      <= nxt_k;
            eng_a_q <= tile_a;
            eng_b_q <= tile_b;
            if (last) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              eng_start_q <= 1'b1;
              state       <= ISSUE;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign eng.eng_start = eng_start_q;
  assign eng.eng_A     = eng_a_q;
  assign eng.eng_B     = eng_b_q;
  assign C             = c_q;

`ifdef MATMUL_SCHED_PERF_EN
  logic [15:0] perf_q;

  // Busy-cycle counter; restarts on accept, holds once busy drops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      perf_q <= '0;
    else if (state == IDLE && start)
      perf_q <= '0;
    else if (busy && perf_q != 16'hFFFF)
      perf_q <= perf_q + 16'd1;
  end

  assign perf_cycles = perf_q;
`endif

endmodule

// File: tb/tb_matmul_tile_sched.sv
// Directed bench for matmul_tile_sched (DIM=4 and DIM=2) with a 6-cycle 2x2 engine stub.
module tb_matmul_tile_sched;

  logic clk, rst;
  logic start4, start2;
  logic [3:0][3:0][7:0]  A4, B4;
  logic [3:0][3:0][17:0] C4;
  logic [1:0][1:0][7:0]  A2, B2;
  logic [1:0][1:0][16:0] C2;
  logic busy4, done4, busy2, done2;
`ifdef MATMUL_SCHED_PERF_EN
  logic [15:0] perf4, perf2;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  matmul_tile_sched_if #(.BIT_PREC(8)) e4 ();
  matmul_tile_sched_if #(.BIT_PREC(8)) e2 ();

  matmul_tile_sched #(.BIT_PREC(8), .DIM(4)) u4 (
    .clk(clk), .rst(rst), .start(start4), .A(A4), .B(B4),
    .busy(busy4), .done(done4), .C(C4),
`ifdef MATMUL_SCHED_PERF_EN
    .perf_cycles(perf4),
`endif
    .eng(e4.master));

  matmul_tile_sched #(.BIT_PREC(8), .DIM(2)) u2 (
    .clk(clk), .rst(rst), .start(start2), .A(A2), .B(B2),
    .busy(busy2), .done(done2), .C(C2),
`ifdef MATMUL_SCHED_PERF_EN
    .perf_cycles(perf2),
`endif
    .eng(e2.master));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Plain 2x2 signed product used by the engine stubs.
  function automatic logic [1:0][1:0][16:0] prod(input logic [1:0][1:0][7:0] a,
                                                  input logic [1:0][1:0][7:0] b);
    logic [1:0][1:0][16:0] p;
    p = '0;
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 2; c++)
        p[r][c] = 17'(int'($signed(a[r][0])) * int'($signed(b[0][c]))
                    + int'($signed(a[r][1])) * int'($signed(b[1][c])));
    return p;
  endfunction

  // Engine stubs: start sampled when idle, valid 6 cycles after the start cycle.
  int e4_cnt, e2_cnt;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      e4_cnt <= 0; e4.eng_valid <= 1'b0; e4.eng_C <= '0;
    end else begin
      e4.eng_valid <= 1'b0;
      if (e4_cnt == 0) begin
        if (e4.eng_start) begin e4_cnt <= 1; e4.eng_C <= prod(e4.eng_A, e4.eng_B); end
      end else if (e4_cnt == 5) begin e4.eng_valid <= 1'b1; e4_cnt <= 6; end
      else if (e4_cnt == 6) e4_cnt <= 0;
      else e4_cnt <= e4_cnt + 1;
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      e2_cnt <= 0; e2.eng_valid <= 1'b0; e2.eng_C <= '0;
    end else begin
      e2.eng_valid <= 1'b0;
      if (e2_cnt == 0) begin
        if (e2.eng_start) begin e2_cnt <= 1; e2.eng_C <= prod(e2.eng_A, e2.eng_B); end
      end else if (e2_cnt == 5) begin e2.eng_valid <= 1'b1; e2_cnt <= 6; end
      else if (e2_cnt == 6) e2_cnt <= 0;
      else e2_cnt <= e2_cnt + 1;
    end
  end

  // One DIM=4 run; latency counted in cycles after the accept cycle.
  task automatic run4(input logic [3:0][3:0][7:0] a, input logic [3:0][3:0][7:0] b,
                      input int resend_at, output int lat, output int pulses);
    @(negedge clk);
    A4 = a; B4 = b; start4 = 1'b1;
    lat = -1; pulses = 0;
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      start4 = (n == resend_at);
      if (n == resend_at) A4 = '0;
      if (e4.eng_start) pulses++;
      if (n == 1) chk("busy_after_accept", longint'(busy4), 1);
      if (done4) begin lat = n; break; end
    end
    start4 = 1'b0;
    if (lat < 0) chk("done_timeout", 0, 1);
    else chk("busy_in_done", longint'(busy4), 1);
    @(negedge clk);
    chk("busy_after_done", longint'(busy4), 0);
  endtask

  logic [3:0][3:0][7:0] id4, ramp4, all127, allm128;
  int lat, pulses, extra;

  initial begin
    rst = 1'b1; start4 = 1'b0; start2 = 1'b0;
    A4 = '0; B4 = '0; A2 = '0; B2 = '0;
    id4 = '0; ramp4 = '0;
    for (int r = 0; r < 4; r++) begin
      id4[r][r] = 8'd1;
      for (int c = 0; c < 4; c++) begin
        ramp4[r][c]   = 8'(4 * r + c);
        all127[r][c]  = 8'd127;
        allm128[r][c] = 8'h80;
      end
    end
    repeat (3) @(negedge clk);

    chk("rst_busy", longint'(busy4), 0);
    chk("rst_done", longint'(done4), 0);
    chk("rst_eng_start", longint'(e4.eng_start), 0);
    chk("rst_c_zero", longint'(C4 == '0), 1);
    chk("rst_eng_a_zero", longint'(e4.eng_A == '0), 1);
    chk("rst_busy2", longint'(busy2), 0);
    rst = 1'b0;
    @(negedge clk);

    // Identity times ramp.
    run4(id4, ramp4, 0, lat, pulses);
    chk("id_latency", lat, 57);
    chk("id_pulses", pulses, 8);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        chk($sformatf("id_c%0d%0d", r, c), longint'($signed(C4[r][c])), 4 * r + c);
`ifdef MATMUL_SCHED_PERF_EN
    chk("perf_after_done", longint'(perf4), 57);
    repeat (10) @(negedge clk);
    chk("perf_held", longint'(perf4), 57);
`endif
    repeat (5) @(negedge clk);
    chk("c_held_idle", longint'($signed(C4[3][2])), 14);

    // Positive extreme.
    run4(all127, all127, 0, lat, pulses);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        chk($sformatf("max_c%0d%0d", r, c), longint'($signed(C4[r][c])), 64516);

    // Negative extreme.
    run4(allm128, all127, 0, lat, pulses);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        chk($sformatf("neg_c%0d%0d", r, c), longint'($signed(C4[r][c])), -65024);

    // Start while busy (with A zeroed at the same time) must not disturb the run.
    run4(id4, ramp4, 10, lat, pulses);
    chk("busy_start_latency", lat, 57);
    chk("busy_start_pulses", pulses, 8);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        chk($sformatf("bs_c%0d%0d", r, c), longint'($signed(C4[r][c])), 4 * r + c);
    extra = 0;
    for (int n = 0; n < 70; n++) begin
      @(negedge clk);
      if (done4) extra++;
    end
    chk("busy_start_extra_done", extra, 0);

    // Reset 20 cycles after accept.
    @(negedge clk);
    A4 = all127; B4 = all127; start4 = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      start4 = 1'b0;
    end
    rst = 1'b1;
    #1;
    chk("midrst_busy", longint'(busy4), 0);
    chk("midrst_c_zero", longint'(C4 == '0), 1);
    chk("midrst_eng_start", longint'(e4.eng_start), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Fresh run: ramp times identity.
    run4(ramp4, id4, 0, lat, pulses);
    chk("fresh_latency", lat, 57);
    chk("fresh_pulses", pulses, 8);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        chk($sformatf("fr_c%0d%0d", r, c), longint'($signed(C4[r][c])), 4 * r + c);

    // DIM=2 instance: single tile job.
    @(negedge clk);
    A2[0][0] = 8'd1; A2[0][1] = 8'd2; A2[1][0] = 8'd3; A2[1][1] = 8'd4;
    B2[0][0] = 8'd5; B2[0][1] = 8'd6; B2[1][0] = 8'd7; B2[1][1] = 8'd8;
    start2 = 1'b1;
    lat = -1;
    for (int n = 1; n <= 50; n++) begin
      @(negedge clk);
      start2 = 1'b0;
      if (done2) begin lat = n; break; end
    end
    chk("dim2_latency", lat, 8);
    chk("dim2_c00", longint'($signed(C2[0][0])), 19);
    chk("dim2_c01", longint'($signed(C2[0][1])), 22);
    chk("dim2_c10", longint'($signed(C2[1][0])), 43);
    chk("dim2_c11", longint'($signed(C2[1][1])), 50);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
